// File: rtl/input_port_arbiter_if.sv
// input_port_arbiter_if: stream bundle between per-port converters,
// the arbiter and the downstream packet FIFO.
// Signals:
//   s_axis_*    NUM_PORTS packed input streams (port i at slice i)
//   must_read   per-port urgency, conv_error per-port overflow pulse
//   m_axis_*    merged output stream, grant_port granted index
// Modports: slave = arbiter side, master = driver/monitor side.
interface input_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            must_read;
  logic [NUM_PORTS-1:0]            conv_error;

  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic [USER_WIDTH-1:0]           m_axis_tuser;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
  logic [PW-1:0]                   grant_port;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser,
    input  s_axis_tvalid, s_axis_tlast,
    input  must_read, conv_error, m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser,
    output m_axis_tvalid, m_axis_tlast, grant_port
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser,
    output s_axis_tvalid, s_axis_tlast,
    output must_read, conv_error, m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser,
    input  m_axis_tvalid, m_axis_tlast, grant_port
  );
endinterface

// File: rtl/input_port_arbiter.sv
// input_port_arbiter: packet-granular round-robin merge of NUM_PORTS
// AXI-Stream inputs, with must_read urgency taking priority.
// Ports:
//   axi_aclk, axi_resetn (async, active-low)
//   bus  input_port_arbiter_if.slave (s_axis_*, must_read,
//        conv_error, m_axis_*, grant_port)
// Option INPUT_PORT_ARBITER_STATS_EN adds stat_pkt_cnt,
// stat_err_cnt and stat_urgent_cnt counter outputs.
module input_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input  logic axi_aclk,
  input  logic axi_resetn,
  input_port_arbiter_if.slave bus
`ifdef INPUT_PORT_ARBITER_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] stat_pkt_cnt,
  output logic [NUM_PORTS*16-1:0] stat_err_cnt,
  output logic [31:0]             stat_urgent_cnt
`endif
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] grant_q, grant_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] urg;
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;
  logic                 pick_urg;
  logic                 hs;
  logic                 pkt_done;

  // First set bit of vec at or after ptr, cyclic; MSB = found.
  // Scanning k downward lets the smallest offset win.
  function automatic logic [PW:0] first_from(
    input logic [NUM_PORTS-1:0] vec,
    input logic [PW-1:0]        ptr
  );
    logic [PW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_PORTS);
      if (vec[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    req      = bus.s_axis_tvalid;
    urg      = req & bus.must_read;
    pick_urg = |urg;
    {pick_vld, pick_idx} = pick_urg ?
      first_from(urg, rr_ptr_q) :
      first_from(req, rr_ptr_q);

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    hs       = 1'b0;
    pkt_done = 1'b0;

    bus.m_axis_tdata  = '0;
    bus.m_axis_tkeep  = '0;
    bus.m_axis_tuser  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.s_axis_tready = '0;
    bus.grant_port    = grant_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bus.m_axis_tvalid = bus.s_axis_tvalid[grant_q];
        bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
        bus.m_axis_tdata  =
          bus.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        bus.m_axis_tkeep  =
          bus.s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        bus.m_axis_tuser  =
          bus.s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
        bus.s_axis_tready[grant_q] = bus.m_axis_tready;
        hs = bus.s_axis_tvalid[grant_q] & bus.m_axis_tready;
        pkt_done = hs & bus.s_axis_tlast[grant_q];
        if (pkt_done) begin
          rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ?
            '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

`ifdef INPUT_PORT_ARBITER_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_PORTS];
  logic [31:0] pkt_cnt_d [NUM_PORTS];
  logic [15:0] err_cnt_q [NUM_PORTS];
  logic [15:0] err_cnt_d [NUM_PORTS];
  logic [31:0] urg_cnt_q, urg_cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (pkt_done && grant_q == PW'(i))
        pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
      err_cnt_d[i] = err_cnt_q[i] + 16'(bus.conv_error[i]);
    end
    urg_cnt_d = urg_cnt_q;
    if (state_q == IDLE && pick_vld && pick_urg)
      urg_cnt_d = urg_cnt_q + 32'd1;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
      urg_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
        err_cnt_q[i] <= err_cnt_d[i];
      end
      urg_cnt_q <= urg_cnt_d;
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    stat_err_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
      stat_err_cnt[i*16 +: 16] = err_cnt_q[i];
    end
  end

  assign stat_urgent_cnt = urg_cnt_q;
`endif

endmodule
